// File: rtl/lsu_mem_ctrl_if.sv
// Signal bundle between a load/store requester, lsu_mem_ctrl and the data memory.
// master = requester/memory side, slave = the controller.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: decodes RISC-V widths and flags illegal/misaligned accesses.
// Define LSU_MISALIGN_SPLIT_EN to service misaligned accesses as ascending byte accesses.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  lsu_mem_ctrl_if.slave bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t state, next_state;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  access_ok;

  function automatic logic legal_code(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  assign access_ok = legal_code(we_q, funct3_q) && !misaligned(funct3_q, addr_q[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]            cnt_q;
  logic                  split_last;
  logic [DATA_WIDTH-1:0] split_word;
  logic [DATA_WIDTH-1:0] split_ext;

  // Last byte index is 1 for halfwords and 3 for words.
  assign split_last = (cnt_q == {funct3_q[1], 1'b1});

  always_comb begin
    split_word = rdata_q;
    split_word[{cnt_q, 3'b000} +: 8] = bus.mem_rd_data[7:0];
  end

  always_comb begin
    case (funct3_q)
      3'b001:  split_ext = {{(DATA_WIDTH-16){split_word[15]}}, split_word[15:0]};
      3'b101:  split_ext = {{(DATA_WIDTH-16){1'b0}}, split_word[15:0]};
      default: split_ext = split_word;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (legal_code(bus.req_we, bus.req_funct3) &&
              misaligned(bus.req_funct3, bus.req_addr[1:0]))
            next_state = SPLIT;
          else
`endif
            next_state = ACCESS;
        end
      end
      ACCESS: next_state = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: if (split_last) next_state = RESP;
`endif
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result registers are cleared on acceptance so stores and errors respond with zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ACCESS: begin
          err_q <= !access_ok;
          if (access_ok && !we_q) rdata_q <= bus.mem_rd_data;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          cnt_q <= cnt_q + 2'd1;
          if (!we_q) rdata_q <= split_last ? split_ext : split_word;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.rsp_valid   = (state == RESP);
    bus.rsp_err     = (state == RESP) && err_q;
    bus.rsp_rdata   = (state == RESP) ? rdata_q : '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_funct3  = 3'b010;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    case (state)
      ACCESS: begin
        if (access_ok) begin
          bus.mem_wr_en   = we_q;
          bus.mem_funct3  = funct3_q;
          bus.mem_addr    = addr_q;
          bus.mem_wr_data = wdata_q;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        bus.mem_wr_en   = we_q;
        bus.mem_funct3  = we_q ? 3'b000 : 3'b100;
        bus.mem_addr    = addr_q + ADDR_WIDTH'(cnt_q);
        bus.mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: byte-addressed memory model, directed vector table,
// plus hand-written split-store and reset-abort sequences.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  lsu_mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory model: 256 bytes, little-endian, combinational read with extension.
  logic [7:0] mem [0:255] = '{default: 8'h00};
  int wr_count = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
  } wr_t;
  wr_t wr_log[$];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_count <= wr_count + 1;
      wr_log.push_back('{bus.mem_addr, bus.mem_funct3, bus.mem_wr_data});
      case (bus.mem_funct3)
        3'b000: mem[bus.mem_addr[7:0]] <= bus.mem_wr_data[7:0];
        3'b001: begin
          mem[bus.mem_addr[7:0]]         <= bus.mem_wr_data[7:0];
          mem[bus.mem_addr[7:0] + 8'd1]  <= bus.mem_wr_data[15:8];
        end
        3'b010: begin
          mem[bus.mem_addr[7:0]]         <= bus.mem_wr_data[7:0];
          mem[bus.mem_addr[7:0] + 8'd1]  <= bus.mem_wr_data[15:8];
          mem[bus.mem_addr[7:0] + 8'd2]  <= bus.mem_wr_data[23:16];
          mem[bus.mem_addr[7:0] + 8'd3]  <= bus.mem_wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic [7:0] ra;
    ra = bus.mem_addr[7:0];
    case (bus.mem_funct3)
      3'b000:  bus.mem_rd_data = {{24{mem[ra][7]}}, mem[ra]};
      3'b001:  bus.mem_rd_data = {{16{mem[ra + 8'd1][7]}}, mem[ra + 8'd1], mem[ra]};
      3'b010:  bus.mem_rd_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
      3'b100:  bus.mem_rd_data = {24'h0, mem[ra]};
      3'b101:  bus.mem_rd_data = {16'h0, mem[ra + 8'd1], mem[ra]};
      default: bus.mem_rd_data = 32'h0;
    endcase
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic e,
                              input logic [31:0] rd, input int lat, input int wr);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_wr = wr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "/req_ready"},   32'(bus.req_ready),   32'd1);
    checkOutput({tag, "/rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    checkOutput({tag, "/rsp_err"},     32'(bus.rsp_err),     32'd0);
    checkOutput({tag, "/rsp_rdata"},   bus.rsp_rdata,        32'd0);
    checkOutput({tag, "/mem_wr_en"},   32'(bus.mem_wr_en),   32'd0);
    checkOutput({tag, "/mem_funct3"},  32'(bus.mem_funct3),  32'd2);
    checkOutput({tag, "/mem_addr"},    bus.mem_addr,         32'd0);
    checkOutput({tag, "/mem_wr_data"}, bus.mem_wr_data,      32'd0);
  endtask

  // Latency counts the acceptance cycle as 0; each wait is bounded to 20 cycles.
  task automatic applyStimulus(input vec_t v, output logic got, output logic err,
                               output logic [31:0] rdata, output int lat,
                               output int writes, output logic pulse_ok);
    int waits;
    int wr_start;
    got = 1'b0; err = 1'bx; rdata = 'x; lat = 0; pulse_ok = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    wr_start = wr_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) begin
        got   = 1'b1;
        err   = bus.rsp_err;
        rdata = bus.rsp_rdata;
      end
    end
    writes = wr_count - wr_start;
    @(negedge clk);
    pulse_ok = !bus.rsp_valid;
  endtask

  task automatic runVec(input vec_t v);
    logic got, err, pulse_ok;
    logic [31:0] rdata;
    int lat, writes;
    applyStimulus(v, got, err, rdata, lat, writes, pulse_ok);
    checkOutput({v.name, "/responded"}, 32'(got),      32'd1);
    checkOutput({v.name, "/rsp_err"},   32'(err),      32'(v.exp_err));
    checkOutput({v.name, "/rsp_rdata"}, rdata,         v.exp_rdata);
    checkOutput({v.name, "/latency"},   32'(lat),      32'(v.exp_lat));
    checkOutput({v.name, "/writes"},    32'(writes),   32'(v.exp_wr));
    checkOutput({v.name, "/one_pulse"}, 32'(pulse_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int log_start;
    int n_new;
    logic seen;

    vecs.push_back(mk("sw_10",   1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1));
    vecs.push_back(mk("lw_10",   0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0));
    vecs.push_back(mk("sw_20",   1, 3'b010, 32'h20, 32'h000080F0, 0, 32'h0,        2, 1));
    vecs.push_back(mk("lb_20",   0, 3'b000, 32'h20, 32'h0,        0, 32'hFFFFFFF0, 2, 0));
    vecs.push_back(mk("lbu_20",  0, 3'b100, 32'h20, 32'h0,        0, 32'h000000F0, 2, 0));
    vecs.push_back(mk("lh_20",   0, 3'b001, 32'h20, 32'h0,        0, 32'hFFFF80F0, 2, 0));
    vecs.push_back(mk("lhu_20",  0, 3'b101, 32'h20, 32'h0,        0, 32'h000080F0, 2, 0));
    vecs.push_back(mk("sw_30",   1, 3'b010, 32'h30, 32'hCAFEF00D, 0, 32'h0,        2, 1));
    vecs.push_back(mk("sbad_30", 1, 3'b100, 32'h30, 32'h12345678, 1, 32'h0,        2, 0));
    vecs.push_back(mk("lw_30",   0, 3'b010, 32'h30, 32'h0,        0, 32'hCAFEF00D, 2, 0));
    vecs.push_back(mk("lbad_30", 0, 3'b011, 32'h30, 32'h0,        1, 32'h0,        2, 0));
    vecs.push_back(mk("sbad_33", 1, 3'b110, 32'h33, 32'hFFFFFFFF, 1, 32'h0,        2, 0));
    vecs.push_back(mk("sh_22",   1, 3'b001, 32'h22, 32'h0000A5A5, 0, 32'h0,        2, 1));
    vecs.push_back(mk("lw_20b",  0, 3'b010, 32'h20, 32'h0,        0, 32'hA5A580F0, 2, 0));
    vecs.push_back(mk("lb_23",   0, 3'b000, 32'h23, 32'h0,        0, 32'hFFFFFFA5, 2, 0));
    vecs.push_back(mk("sw_41",   1, 3'b010, 32'h41, 32'h11223344, !SPLIT_ON, 32'h0,
                      SPLIT_ON ? 5 : 2, SPLIT_ON ? 4 : 0));
    vecs.push_back(mk("lw_41",   0, 3'b010, 32'h41, 32'h0, !SPLIT_ON,
                      SPLIT_ON ? 32'h11223344 : 32'h0, SPLIT_ON ? 5 : 2, 0));
    vecs.push_back(mk("lw_40",   0, 3'b010, 32'h40, 32'h0, 0,
                      SPLIT_ON ? 32'h22334400 : 32'h0, 2, 0));
    vecs.push_back(mk("lh_21",   0, 3'b001, 32'h21, 32'h0, !SPLIT_ON,
                      SPLIT_ON ? 32'hFFFFA580 : 32'h0, SPLIT_ON ? 3 : 2, 0));
    vecs.push_back(mk("lhu_21",  0, 3'b101, 32'h21, 32'h0, !SPLIT_ON,
                      SPLIT_ON ? 32'h0000A580 : 32'h0, SPLIT_ON ? 3 : 2, 0));
    vecs.push_back(mk("sh_45",   1, 3'b001, 32'h45, 32'h00007788, !SPLIT_ON, 32'h0,
                      SPLIT_ON ? 3 : 2, SPLIT_ON ? 2 : 0));
    vecs.push_back(mk("lw_44",   0, 3'b010, 32'h44, 32'h0, 0,
                      SPLIT_ON ? 32'h00778811 : 32'h0, 2, 0));
    vecs.push_back(mk("sb_top",  1, 3'b000, 32'hFFFFFFFF, 32'h0000005A, 0, 32'h0, 2, 1));
    vecs.push_back(mk("sb_0",    1, 3'b000, 32'h00000000, 32'h0000003C, 0, 32'h0, 2, 1));
    vecs.push_back(mk("lhu_wrap", 0, 3'b101, 32'hFFFFFFFF, 32'h0, !SPLIT_ON,
                      SPLIT_ON ? 32'h00003C5A : 32'h0, SPLIT_ON ? 3 : 2, 0));

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    foreach (vecs[i]) runVec(vecs[i]);

    // Split store byte sequence: one byte write per cycle at ascending addresses.
    log_start = wr_log.size();
    runVec(mk("sw_41_again", 1, 3'b010, 32'h41, 32'h11223344, !SPLIT_ON, 32'h0,
              SPLIT_ON ? 5 : 2, SPLIT_ON ? 4 : 0));
    n_new = wr_log.size() - log_start;
    checkOutput("split_log/count", 32'(n_new), SPLIT_ON ? 32'd4 : 32'd0);
    for (int i = 0; i < n_new; i++) begin
      logic [31:0] src;
      src = 32'h11223344;
      checkOutput($sformatf("split_log/addr%0d", i), wr_log[log_start + i].addr, 32'h41 + 32'(i));
      checkOutput($sformatf("split_log/f3_%0d", i), 32'(wr_log[log_start + i].f3), 32'd0);
      checkOutput($sformatf("split_log/data%0d", i), wr_log[log_start + i].data,
                  {24'h0, src[8*i +: 8]});
    end

    // Reset abort in the middle of a misaligned store.
    runVec(mk("clr_40", 1, 3'b010, 32'h40, 32'h0, 0, 32'h0, 2, 1));
    runVec(mk("clr_44", 1, 3'b010, 32'h44, 32'h0, 0, 32'h0, 2, 1));
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h41;
    bus.req_wdata  = 32'hAABBCCDD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (SPLIT_ON ? 1 : 0) @(posedge clk);
    #2 reset = 1'b1;
    #1 checkIdleOutputs("midreset");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    checkOutput("midreset/no_rsp", 32'(seen), 32'd0);
    checkOutput("midreset/byte41", 32'(mem[8'h41]), SPLIT_ON ? 32'hDD : 32'h00);
    checkOutput("midreset/byte42", 32'(mem[8'h42]), 32'h00);
    checkOutput("midreset/byte43", 32'(mem[8'h43]), 32'h00);

    runVec(mk("post_rst_lw_10", 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
